act_pipe_unit: RTL and testbench

- Parametrised, multi-lane activation stage that follows the MAC/accumulator register path in the NPU datapath.
- Generalises the single-lane ReLU register to LANES parallel signed lanes with four runtime modes: bypass, ReLU, leaky ReLU and clipped ReLU.
- Two-stage valid/ready pipeline with full throughput, backpressure and a synchronous flush.

---
 rtl/npu_act_pkg.sv | 14 +
 rtl/act_lane.sv | 49 ++++
 rtl/act_pipe_unit.sv | 155 +++++++++++++++
 tb/tb_act_pipe_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_act_pkg.sv
// Shared activation-stage definitions: mode encodings and default lane geometry.
package npu_act_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_LANES  = 4;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_LEAKY  = 2'b10,
    ACT_CLIP   = 2'b11
  } act_mode_e;

endpackage

// File: rtl/act_lane.sv
// Single-lane combinational activation: bypass, ReLU, leaky ReLU, clipped ReLU.
module act_lane
  import npu_act_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEAK_SHIFT = 3,
  parameter int CLIP_VAL   = 'h0600
) (
  input  logic [DATA_W-1:0] x,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] y,
  output logic              is_neg,
  output logic              is_clip
);

  localparam logic signed [DATA_W-1:0] CLIP_S = DATA_W'(CLIP_VAL);

  logic signed [DATA_W-1:0] xs;
  logic                     over_clip;

  assign xs        = x;
  assign is_neg    = x[DATA_W-1];
  assign over_clip = xs > CLIP_S;

  always_comb begin
    y       = x;
    is_clip = 1'b0;
    case (act_mode_e'(mode))
      ACT_BYPASS: y = x;
      ACT_RELU: begin
        if (is_neg) y = '0;
      end
      // Arithmetic shift floors toward minus infinity, so small negatives settle at -1.
      ACT_LEAKY: begin
        if (is_neg) y = xs >>> LEAK_SHIFT;
      end
      ACT_CLIP: begin
        if (is_neg) begin
          y = '0;
        end else if (over_clip) begin
          y       = CLIP_S;
          is_clip = 1'b1;
        end
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/act_pipe_unit.sv
// Two-stage valid/ready multi-lane activation pipeline with flush.
// Optional lane statistics counters are enabled by defining ACT_STATS_EN.
module act_pipe_unit
  import npu_act_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LANES      = DEF_LANES,
  parameter int LEAK_SHIFT = 3,
  parameter int CLIP_VAL   = 'h0600,
  parameter int CNT_W      = 16
) (
  input  logic                    CLKEXT,
  input  logic                    RST_GLO_N,
  input  logic                    FLUSH,
  input  logic [1:0]              MODE_ACT,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] Data_Reg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] ACT_OUT
`ifdef ACT_STATS_EN
  ,
  input  logic                    STATS_CLR,
  output logic [CNT_W-1:0]        neg_cnt,
  output logic [CNT_W-1:0]        clip_cnt
`endif
);

  localparam int BUS_W = LANES * DATA_W;

  logic             s1_valid_reg, s1_valid_next;
  logic [BUS_W-1:0] s1_data_reg;
  logic [1:0]       s1_mode_reg;
  logic             s2_valid_reg, s2_valid_next;
  logic [BUS_W-1:0] s2_data_reg;

  logic             s1_ready, s2_ready, in_fire, s2_load;
  logic [BUS_W-1:0] act_data;
  logic [LANES-1:0] lane_neg, lane_clip;

  assign s2_ready = !s2_valid_reg || out_ready;
  assign s1_ready = !s1_valid_reg || s2_ready;
  // Reset gating keeps the source from launching beats into a held pipeline.
  assign in_ready = s1_ready && !FLUSH && RST_GLO_N;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_reg && s2_ready;

  always_comb begin
    s1_valid_next = s1_valid_reg;
    s2_valid_next = s2_valid_reg;
    if (FLUSH) begin
      s1_valid_next = 1'b0;
      s2_valid_next = 1'b0;
    end else begin
      if (s1_ready) s1_valid_next = in_fire;
      if (s2_ready) s2_valid_next = s1_valid_reg;
    end
  end

  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_mode_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      s2_valid_reg <= s2_valid_next;
      if (in_fire) begin
        s1_data_reg <= Data_Reg;
        s1_mode_reg <= MODE_ACT;
      end
      if (s2_load) s2_data_reg <= act_data;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      act_lane #(
        .DATA_W    (DATA_W),
        .LEAK_SHIFT(LEAK_SHIFT),
        .CLIP_VAL  (CLIP_VAL)
      ) u_lane (
        .x      (s1_data_reg[gi*DATA_W +: DATA_W]),
        .mode   (s1_mode_reg),
        .y      (act_data[gi*DATA_W +: DATA_W]),
        .is_neg (lane_neg[gi]),
        .is_clip(lane_clip[gi])
      );
    end
  endgenerate

  assign out_valid = s2_valid_reg;
  assign ACT_OUT   = s2_data_reg;

`ifdef ACT_STATS_EN
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PC_W;

  logic [LANES-1:0] s2_neg_reg, s2_clip_reg;
  logic [PC_W-1:0]  neg_pc, clip_pc;
  logic [CNT_W-1:0] neg_cnt_reg, clip_cnt_reg;
  logic             out_fire;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [PC_W-1:0]  n);
    logic [SUM_W-1:0] s;
    s = SUM_W'(c) + SUM_W'(n);
    return (s > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign out_fire = s2_valid_reg && out_ready;

  always_comb begin
    neg_pc  = '0;
    clip_pc = '0;
    for (int i = 0; i < LANES; i++) begin
      neg_pc  = neg_pc + PC_W'(s2_neg_reg[i]);
      clip_pc = clip_pc + PC_W'(s2_clip_reg[i]);
    end
  end

  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      s2_neg_reg   <= '0;
      s2_clip_reg  <= '0;
      neg_cnt_reg  <= '0;
      clip_cnt_reg <= '0;
    end else begin
      if (s2_load) begin
        s2_neg_reg  <= lane_neg;
        s2_clip_reg <= lane_clip;
      end
      if (STATS_CLR) begin
        neg_cnt_reg  <= '0;
        clip_cnt_reg <= '0;
      end else if (out_fire) begin
        neg_cnt_reg  <= sat_add(neg_cnt_reg, neg_pc);
        clip_cnt_reg <= sat_add(clip_cnt_reg, clip_pc);
      end
    end
  end

  assign neg_cnt  = neg_cnt_reg;
  assign clip_cnt = clip_cnt_reg;
`else
  logic             unused_flags;
  logic [CNT_W-1:0] unused_cnt;
  assign unused_flags = ^{lane_neg, lane_clip};
  assign unused_cnt   = '0;
`endif

endmodule

// File: tb/tb_act_pipe_unit.sv
// Scoreboard bench for act_pipe_unit: vector table, backpressure, flush, mode change, reset.
module tb_act_pipe_unit;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
`ifdef ACT_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic        CLKEXT = 1'b0;
  logic        RST_GLO_N;
  logic        FLUSH;
  logic [1:0]  MODE_ACT;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] Data_Reg;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ACT_OUT;
`ifdef ACT_STATS_EN
  logic             STATS_CLR;
  logic [CNT_W-1:0] neg_cnt;
  logic [CNT_W-1:0] clip_cnt;
`endif

  always #5 CLKEXT = ~CLKEXT;

  act_pipe_unit #(
    .DATA_W(DATA_W), .LANES(LANES), .LEAK_SHIFT(3), .CLIP_VAL('h0600), .CNT_W(CNT_W)
  ) dut (
    .CLKEXT(CLKEXT), .RST_GLO_N(RST_GLO_N), .FLUSH(FLUSH), .MODE_ACT(MODE_ACT),
    .in_valid(in_valid), .in_ready(in_ready), .Data_Reg(Data_Reg),
    .out_valid(out_valid), .out_ready(out_ready), .ACT_OUT(ACT_OUT)
`ifdef ACT_STATS_EN
    , .STATS_CLR(STATS_CLR), .neg_cnt(neg_cnt), .clip_cnt(clip_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] din;
    logic [63:0] dout;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vtab[8];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          cyc      = 0;
  int          beat_no  = 0;
  bit          or_mode  = 1'b0;
  bit          hold_en  = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] prev_out = '0;

  always @(posedge CLKEXT) cyc <= cyc + 1;

  function automatic logic [63:0] pk(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic send(input logic [1:0] m, input logic [63:0] d, input logic [63:0] e,
                      input bit lat);
    bit   done = 1'b0;
    exp_t it;
    MODE_ACT = m;
    Data_Reg = d;
    in_valid = 1'b1;
    for (int w = 0; w < 200 && !done; w++) begin
      @(negedge CLKEXT);
      if (in_ready) begin
        it.data = e;
        it.acc  = cyc;
        it.lat  = lat;
        exp_q.push_back(it);
        done = 1'b1;
      end
      @(posedge CLKEXT); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge CLKEXT);
      w++;
    end
    @(posedge CLKEXT); #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLKEXT);
      if (RST_GLO_N) begin
        if (hold_en && stall_prev) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", ACT_OUT, prev_out);
        end
        stall_prev = out_valid && !out_ready;
        prev_out   = ACT_OUT;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_beat", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            $display("beat %0d @cyc %0d: out=%h exp=%h", beat_no, cyc, ACT_OUT, e.data);
            beat_no++;
            chk("data", ACT_OUT, e.data);
            if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
          end
        end
      end
    end
  end

  // Downstream ready pattern 1,0,0 repeating when enabled.
  initial begin
    int ph = 0;
    forever begin
      @(posedge CLKEXT); #2;
      if (or_mode) begin
        out_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  initial begin
    logic [15:0] v;
    vtab[0] = '{2'b01, pk(16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF), pk(16'h7FFF, 16'h0000, 16'h0001, 16'h0000)};
    vtab[1] = '{2'b10, pk(16'hFFF8, 16'hFFFF, 16'hFF00, 16'h0040), pk(16'hFFFF, 16'hFFFF, 16'hFFE0, 16'h0040)};
    vtab[2] = '{2'b11, pk(16'h0700, 16'h0600, 16'h05FF, 16'h8001), pk(16'h0600, 16'h0600, 16'h05FF, 16'h0000)};
    vtab[3] = '{2'b00, pk(16'h8000, 16'h1234, 16'hFFFF, 16'h0000), pk(16'h8000, 16'h1234, 16'hFFFF, 16'h0000)};
    vtab[4] = '{2'b10, pk(16'h8000, 16'h7FFF, 16'hFFF9, 16'h0000), pk(16'hF000, 16'h7FFF, 16'hFFFF, 16'h0000)};
    vtab[5] = '{2'b11, pk(16'h7FFF, 16'h0000, 16'h0601, 16'hFFFF), pk(16'h0600, 16'h0000, 16'h0600, 16'h0000)};
    vtab[6] = '{2'b01, pk(16'h0000, 16'h8001, 16'h4000, 16'hFFFE), pk(16'h0000, 16'h0000, 16'h4000, 16'h0000)};
    vtab[7] = '{2'b10, pk(16'hFFF7, 16'hFFF0, 16'h0001, 16'hFF01), pk(16'hFFFE, 16'hFFFE, 16'h0001, 16'hFFE0)};

    RST_GLO_N = 1'b0;
    FLUSH     = 1'b0;
    MODE_ACT  = 2'b00;
    in_valid  = 1'b0;
    Data_Reg  = '0;
    out_ready = 1'b1;
`ifdef ACT_STATS_EN
    STATS_CLR = 1'b0;
`endif

    repeat (3) @(posedge CLKEXT);
    @(negedge CLKEXT);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_act_out", ACT_OUT, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef ACT_STATS_EN
    chk("rst_neg_cnt", 64'(neg_cnt), 64'd0);
    chk("rst_clip_cnt", 64'(clip_cnt), 64'd0);
`endif
    #2 RST_GLO_N = 1'b1;
    @(posedge CLKEXT); #1;
    @(negedge CLKEXT);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge CLKEXT); #1;

    // Vector table, full-rate with latency checks.
    for (int i = 0; i < 8; i++) send(vtab[i].mode, vtab[i].din, vtab[i].dout, 1'b1);
    drain();

    // Backpressure stream, bypass mode, incrementing lanes.
    hold_en = 1'b1;
    or_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = 16'(i * 4);
      send(2'b00, pk(v, v + 16'd1, v + 16'd2, v + 16'd3), pk(v, v + 16'd1, v + 16'd2, v + 16'd3), 1'b0);
    end
    drain();
    hold_en = 1'b0;

    // Per-beat mode alternation on all-negative lanes.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send(2'b01, {4{16'h8000}}, 64'd0, 1'b0);
      else            send(2'b00, {4{16'h8000}}, {4{16'h8000}}, 1'b0);
    end
    drain();
    or_mode   = 1'b0;
    out_ready = 1'b1;
    @(posedge CLKEXT); #1;

    // Flush with both stages full and a concurrent input beat.
    out_ready = 1'b0;
    send(2'b00, pk(16'h1111, 16'h2222, 16'h3333, 16'h4444), pk(16'h1111, 16'h2222, 16'h3333, 16'h4444), 1'b0);
    send(2'b00, pk(16'h5555, 16'h6666, 16'h7777, 16'h0888), pk(16'h5555, 16'h6666, 16'h7777, 16'h0888), 1'b0);
    MODE_ACT = 2'b00;
    Data_Reg = pk(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    in_valid = 1'b1;
    @(negedge CLKEXT);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge CLKEXT); #1;
    FLUSH = 1'b1;
    @(negedge CLKEXT);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge CLKEXT); #1;
    FLUSH    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge CLKEXT);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge CLKEXT); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge CLKEXT);
    #1;
    send(vtab[4].mode, vtab[4].din, vtab[4].dout, 1'b1);
    drain();

`ifdef ACT_STATS_EN
    STATS_CLR = 1'b1;
    @(posedge CLKEXT); #1;
    STATS_CLR = 1'b0;
    send(vtab[2].mode, vtab[2].din, vtab[2].dout, 1'b0);
    drain();
    chk("clip_cnt", 64'(clip_cnt), 64'd1);
    chk("neg_cnt", 64'(neg_cnt), 64'd1);
    for (int i = 0; i < 5; i++) send(2'b00, {4{16'h8000}}, {4{16'h8000}}, 1'b0);
    drain();
    chk("neg_cnt_sat", 64'(neg_cnt), 64'hF);
    chk("clip_cnt_hold", 64'(clip_cnt), 64'd1);
    STATS_CLR = 1'b1;
    @(posedge CLKEXT); #1;
    STATS_CLR = 1'b0;
    chk("neg_cnt_clr", 64'(neg_cnt), 64'd0);
    chk("clip_cnt_clr", 64'(clip_cnt), 64'd0);
`endif

    // Asynchronous reset with beats in flight.
    out_ready = 1'b0;
    send(2'b01, pk(16'h0101, 16'h0202, 16'h0303, 16'h0404), pk(16'h0101, 16'h0202, 16'h0303, 16'h0404), 1'b0);
    send(2'b01, pk(16'h0505, 16'h0606, 16'h0707, 16'h0808), pk(16'h0505, 16'h0606, 16'h0707, 16'h0808), 1'b0);
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    RST_GLO_N = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_data", ACT_OUT, 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge CLKEXT); #1;
    RST_GLO_N = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge CLKEXT);
    #1;
    send(vtab[2].mode, vtab[2].din, vtab[2].dout, 1'b1);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
